// File: rtl/disp_bcd_pkg.sv
// rtl/disp_bcd_pkg.sv - shared types and sizing helpers for the binary-to-BCD converter
package disp_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DIGITS = 5;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEF_WIDTH);

  // True when DIGITS decimal digits can represent every WIDTH-bit value.
  function automatic bit digits_fit(input int width, input int digits);
    longint p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p > (longint'(1) << width);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble correction cell: add 3 to a BCD digit of 5 or more
module bcd_add3
  import disp_bcd_pkg::*;
(
  input  bcd_digit_t in_i,
  output bcd_digit_t out_o
);

  assign out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;

endmodule

// File: rtl/disp_bcd_conv.sv
// rtl/disp_bcd_conv.sv - iterative binary-to-BCD converter with leading-zero blanking mask
module disp_bcd_conv
  import disp_bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [WIDTH-1:0]      bin_i,
  input  logic                  bin_valid_i,
  output logic                  bin_ready_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [DIGITS-1:0]     blank_mask_o,
  output logic                  bcd_valid_o,
  input  logic                  bcd_ready_i
);

  localparam int CW = cnt_w(WIDTH);
  localparam int AW = 4 * DIGITS;

  if (!digits_fit(WIDTH, DIGITS)) begin : g_bad_digits
    $error("disp_bcd_conv: DIGITS too small for WIDTH");
  end

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  sr_q, sr_d, sr_shift;
  logic [AW-1:0]     acc_q, acc_d, acc_adj, acc_shift;
  logic [AW-1:0]     bcd_q, bcd_d;
  logic [DIGITS-1:0] mask_q, mask_d, mask_new;
  logic              seen_nz;
  logic              unused_acc_msb;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .in_i  (acc_q[4*g +: 4]),
      .out_o (acc_adj[4*g +: 4])
    );
  end

  // The top accumulator bit never carries out because the digit count covers the input range.
  assign {acc_shift, sr_shift} = {acc_adj[AW-2:0], sr_q, 1'b0};
  assign unused_acc_msb        = acc_adj[AW-1];

  always_comb begin
    seen_nz  = 1'b0;
    mask_new = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      seen_nz     = seen_nz | (acc_shift[4*k +: 4] != 4'd0);
      mask_new[k] = seen_nz;
    end
    mask_new[0] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (bin_valid_i) begin
          sr_d    = bin_i;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        acc_d = acc_shift;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = acc_shift;
          mask_d  = mask_new;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bcd_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      mask_q  <= DIGITS'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      mask_q  <= mask_d;
    end
  end

  assign bin_ready_o  = (state_q == IDLE);
  assign bcd_valid_o  = (state_q == DONE);
  assign bcd_o        = bcd_q;
  assign blank_mask_o = mask_q;

endmodule

// File: tb/tb_disp_bcd_conv.sv
// tb/tb_disp_bcd_conv.sv - self-checking bench for disp_bcd_conv against a decimal reference model
module tb_disp_bcd_conv;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [15:0] bin_i = '0;
  logic        bin_valid_i = 1'b0;
  logic        bin_ready_o;
  logic [19:0] bcd_o;
  logic [4:0]  blank_mask_o;
  logic        bcd_valid_o;
  logic        bcd_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  disp_bcd_conv dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .bin_i        (bin_i),
    .bin_valid_i  (bin_valid_i),
    .bin_ready_o  (bin_ready_o),
    .bcd_o        (bcd_o),
    .blank_mask_o (blank_mask_o),
    .bcd_valid_o  (bcd_valid_o),
    .bcd_ready_i  (bcd_ready_i)
  );

  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_mask(input int unsigned v);
    logic [4:0] m;
    int unsigned p;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      m[k] = (k == 0) || (v >= p);
      p = p * 10;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic convert(input int unsigned v, input int hold, input string tag);
    int n;
    n = 0;
    while (!bin_ready_o && n < 50) begin
      tick();
      n++;
    end
    chk({tag, " ready_before"}, 32'(bin_ready_o), 32'd1);
    bin_i = 16'(v);
    bin_valid_i = 1'b1;
    tick();
    bin_valid_i = 1'b0;
    n = 0;
    while (!bcd_valid_o && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd16);
    chk({tag, " bcd"}, 32'(bcd_o), 32'(ref_bcd(v)));
    chk({tag, " mask"}, 32'(blank_mask_o), 32'(ref_mask(v)));
    repeat (hold) begin
      tick();
      chk({tag, " hold_valid"}, 32'(bcd_valid_o), 32'd1);
    end
    bcd_ready_i = 1'b1;
    tick();
    bcd_ready_i = 1'b0;
    chk({tag, " ready_after"}, 32'(bin_ready_o), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int unsigned rv;

    repeat (2) tick();
    chk("reset bcd", 32'(bcd_o), 32'h0);
    chk("reset mask", 32'(blank_mask_o), 32'h1);
    chk("reset valid", 32'(bcd_valid_o), 32'd0);
    reset_i = 1'b0;
    tick();
    chk("reset ready", 32'(bin_ready_o), 32'd1);

    convert(0, 0, "zero");
    convert(65535, 0, "max");
    convert(1234, 0, "n1234");
    convert(9, 0, "n9");
    convert(10000, 1, "n10000");

    // Back-pressure with a stray input while DONE
    bin_i = 16'd4095;
    bin_valid_i = 1'b1;
    tick();
    bin_valid_i = 1'b0;
    n = 0;
    while (!bcd_valid_o && n < 100) begin
      tick();
      n++;
    end
    chk("bp latency", 32'(n), 32'd16);
    for (int i = 0; i < 10; i++) begin
      bin_i = 16'd7;
      bin_valid_i = 1'b1;
      tick();
      chk("bp bcd", 32'(bcd_o), 32'h04095);
      chk("bp bin_ready", 32'(bin_ready_o), 32'd0);
      chk("bp valid", 32'(bcd_valid_o), 32'd1);
    end
    bin_valid_i = 1'b0;
    bcd_ready_i = 1'b1;
    tick();
    bcd_ready_i = 1'b0;
    chk("bp release ready", 32'(bin_ready_o), 32'd1);
    chk("bp release valid", 32'(bcd_valid_o), 32'd0);
    chk("bp release bcd", 32'(bcd_o), 32'h04095);
    tick();
    chk("bp no stray accept", 32'(bin_ready_o), 32'd1);

    // Reset in the middle of a conversion
    bin_i = 16'd500;
    bin_valid_i = 1'b1;
    tick();
    bin_valid_i = 1'b0;
    repeat (8) tick();
    reset_i = 1'b1;
    #1;
    chk("midrst bcd", 32'(bcd_o), 32'h0);
    chk("midrst mask", 32'(blank_mask_o), 32'h1);
    chk("midrst valid", 32'(bcd_valid_o), 32'd0);
    tick();
    reset_i = 1'b0;
    tick();
    chk("midrst ready", 32'(bin_ready_o), 32'd1);
    convert(500, 0, "n500");

    // Throughput with both handshakes held high
    bin_i = 16'd10;
    bin_valid_i = 1'b1;
    bcd_ready_i = 1'b1;
    tick();
    bin_i = 16'd11;
    n = 0;
    while (!bcd_valid_o && n < 100) begin
      tick();
      n++;
    end
    chk("tput first latency", 32'(n), 32'd16);
    chk("tput first bcd", 32'(bcd_o), 32'h00010);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bcd_valid_o && bcd_o == 20'h00011) && n < 100);
    chk("tput spacing", 32'(n), 32'd18);
    chk("tput second mask", 32'(blank_mask_o), 32'h3);
    bin_valid_i = 1'b0;
    repeat (3) tick();
    bcd_ready_i = 1'b0;

    for (int i = 0; i < 20; i++) begin
      rv = $urandom_range(0, 65535);
      convert(rv, int'($urandom_range(0, 3)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
